// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU pipeline.
// Opcodes, reset/vector defaults, fetch state and next-PC select codes.
package cpu_pkg;

  localparam logic [3:0] OP_JMP  = 4'hF;
  localparam logic [3:0] OP_BNE  = 4'hE;
  localparam logic [3:0] OP_ADDI = 4'h3;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'hA;

  localparam logic [15:0] NOP_INSTR      = 16'h0000;
  localparam logic [15:0] INT_VECTOR_DEF = 16'h0000;
  localparam logic [15:0] RESET_PC_DEF   = 16'h0001;

  typedef enum logic {
    RUN,
    ISR
  } fetch_state_t;

  typedef enum logic [2:0] {
    SEL_BR,
    SEL_INT,
    SEL_RET,
    SEL_STALL,
    SEL_JMP,
    SEL_SEQ
  } pc_sel_t;

  function automatic logic is_jmp(
    input logic [15:0] w
  );
    return w[15:12] == OP_JMP;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch address / instruction word bus to instruct_mem.
// The fetch stage is master; the memory is slave.
interface fetch_unit_if;

  logic [15:0] PC;
  logic [15:0] INSTR;

  modport master (
    output PC,
    input  INSTR
  );

  modport slave (
    input  PC,
    output INSTR
  );

endinterface

// File: rtl/pc_next_sel.sv
// Priority mux for the next fetch address.
// Also reports which case won so the top can steer IF/ID.
module pc_next_sel
  import cpu_pkg::*;
#(
  parameter logic [15:0] INT_VECTOR = INT_VECTOR_DEF
) (
  input  logic         br_taken_i,
  input  logic [15:0]  br_target_i,
  input  logic         int_req_i,
  input  logic         int_ret_i,
  input  logic         stall_i,
  input  fetch_state_t state_i,
  input  logic [15:0]  pc_i,
  input  logic [15:0]  epc_i,
  input  logic [15:0]  instr_i,
  output pc_sel_t      sel_o,
  output logic [15:0]  pc_nxt_o
);

  // Highest-priority redirect wins; sequential fetch is the fallback.
  always_comb begin
    sel_o    = SEL_SEQ;
    pc_nxt_o = pc_i + 16'd1;
    if (br_taken_i) begin
      sel_o    = SEL_BR;
      pc_nxt_o = br_target_i;
    end else if (int_req_i && state_i == RUN) begin
      sel_o    = SEL_INT;
      pc_nxt_o = INT_VECTOR;
    end else if (int_ret_i && state_i == ISR) begin
      sel_o    = SEL_RET;
      pc_nxt_o = epc_i;
    end else if (stall_i) begin
      sel_o    = SEL_STALL;
      pc_nxt_o = pc_i;
    end else if (is_jmp(instr_i)) begin
      sel_o    = SEL_JMP;
      pc_nxt_o = {4'h0, instr_i[11:0]};
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, IF/ID register, EPC and
// interrupt state. Memory sits outside on the fetch bus.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [15:0] INT_VECTOR = INT_VECTOR_DEF
) (
  input  logic         CLK,
  input  logic         RST,
  fetch_unit_if.master imem,
  input  logic         STALL,
  input  logic         BR_TAKEN,
  input  logic [15:0]  BR_TARGET,
  input  logic         INT_REQ,
  input  logic         INT_RET,
  output logic [15:0]  IF_INSTR,
  output logic [15:0]  IF_PC,
  output logic         IF_VALID,
  output logic         INT_ACK,
  output logic [15:0]  EPC
);

  fetch_state_t state_q, state_d;
  pc_sel_t      sel;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  if_instr_q, if_instr_d;
  logic [15:0]  if_pc_q, if_pc_d;
  logic         if_valid_q, if_valid_d;
  logic         int_ack_q, int_ack_d;
  logic [15:0]  epc_q, epc_d;

  pc_next_sel #(
    .INT_VECTOR (INT_VECTOR)
  ) u_sel (
    .br_taken_i  (BR_TAKEN),
    .br_target_i (BR_TARGET),
    .int_req_i   (INT_REQ),
    .int_ret_i   (INT_RET),
    .stall_i     (STALL),
    .state_i     (state_q),
    .pc_i        (pc_q),
    .epc_i       (epc_q),
    .instr_i     (imem.INSTR),
    .sel_o       (sel),
    .pc_nxt_o    (pc_d)
  );

  // Steer IF/ID, EPC and state from the winning next-PC case.
  always_comb begin
    state_d    = state_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    int_ack_d  = 1'b0;
    epc_d      = epc_q;
    unique case (sel)
      SEL_BR, SEL_RET, SEL_JMP: begin
        if_instr_d = NOP_INSTR;
        if_pc_d    = pc_q;
        if_valid_d = 1'b0;
        if (sel == SEL_RET) state_d = RUN;
      end
      SEL_INT: begin
        if_instr_d = NOP_INSTR;
        if_pc_d    = pc_q;
        if_valid_d = 1'b0;
        int_ack_d  = 1'b1;
        epc_d      = pc_q;
        state_d    = ISR;
      end
      SEL_STALL: begin
      end
      default: begin
        if_instr_d = imem.INSTR;
        if_pc_d    = pc_q;
        if_valid_d = 1'b1;
      end
    endcase
  end

  // Interrupt mask state register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= RUN;
    else     state_q <= state_d;
  end

  // PC, IF/ID, EPC and interrupt-ack registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q       <= RESET_PC;
      if_instr_q <= NOP_INSTR;
      if_pc_q    <= 16'h0000;
      if_valid_q <= 1'b0;
      int_ack_q  <= 1'b0;
      epc_q      <= 16'h0000;
    end else begin
      pc_q       <= pc_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
      int_ack_q  <= int_ack_d;
      epc_q      <= epc_d;
    end
  end

  assign imem.PC  = pc_q;
  assign IF_INSTR = if_instr_q;
  assign IF_PC    = if_pc_q;
  assign IF_VALID = if_valid_q;
  assign INT_ACK  = int_ack_q;
  assign EPC      = epc_q;

endmodule
